// File: rtl/aes_iter_ctrl.sv
// Iterative AES encryptor: one round datapath reused Nr times, sequenced by an
// IDLE/INIT/ROUND/FINAL/DONE state machine with valid/ready handshakes on both sides.
module aes_iter_ctrl #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  localparam int RW = $clog2(Nr + 1);
  localparam int KW = 128 * (Nr + 1);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box built from its definition: a^254 is the GF(2^8) inverse (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte k of the state is row k%4, column k/4, with byte 0 in the top bits.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Full key schedule, word 0 in the top bits so round key r sits at KW-1-128*r.
  function automatic logic [KW-1:0] keyExpand(input logic [N-1:0] k);
    logic [31:0]   w [4*(Nr+1)];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [KW-1:0] fk;
    rc = 8'h01;
    fk = '0;
    for (int i = 0; i < Nk; i++) w[i] = k[N-1-32*i -: 32];
    for (int i = Nk; i < 4*(Nr+1); i++) begin
      t = w[i-1];
      if ((i % Nk) == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end else if (Nk > 6 && (i % Nk) == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int i = 0; i < 4*(Nr+1); i++) fk[KW-1-32*i -: 32] = w[i];
    return fk;
  endfunction

  state_t        r_fsm;
  state_t        w_fsmNxt;
  logic [RW-1:0] r_rnd;
  logic [127:0]  r_pt;
  logic [127:0]  r_state;
  logic [N-1:0]  r_key;
  logic [KW-1:0] w_fullkeys;
  logic [127:0]  w_rk0;
  logic [127:0]  w_rkRnd;
  logic [127:0]  w_rkLast;
  logic [127:0]  w_roundOut;
  logic [127:0]  w_finalOut;
  logic          w_lastRound;

  assign w_fullkeys  = keyExpand(r_key);
  assign w_rk0       = w_fullkeys[KW-1 -: 128];
  assign w_rkRnd     = w_fullkeys[KW-1-128*int'(r_rnd) -: 128];
  assign w_rkLast    = w_fullkeys[127:0];
  assign w_roundOut  = mixColumns(shiftRows(subBytes(r_state))) ^ w_rkRnd;
  assign w_finalOut  = shiftRows(subBytes(r_state)) ^ w_rkLast;
  assign w_lastRound = (r_rnd == RW'(Nr - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsmNxt;
  end

  always_comb begin
    w_fsmNxt  = IDLE;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        w_fsmNxt = in_valid ? INIT : IDLE;
      end
      INIT:  w_fsmNxt = ROUND;
      ROUND: w_fsmNxt = w_lastRound ? FINAL : ROUND;
      FINAL: w_fsmNxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        w_fsmNxt  = out_ready ? IDLE : DONE;
      end
      default: w_fsmNxt = IDLE;
    endcase
  end

  // The round counter drops back to 0 as it leaves ROUND so it is only non-zero while iterating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rnd   <= '0;
      r_pt    <= '0;
      r_key   <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_pt  <= plaintext;
            r_key <= key;
          end
        end
        INIT: begin
          r_state <= r_pt ^ w_rk0;
          r_rnd   <= RW'(1);
        end
        ROUND: begin
          r_state <= w_roundOut;
          r_rnd   <= w_lastRound ? '0 : r_rnd + 1'b1;
        end
        FINAL:   r_state <= w_finalOut;
        default: r_rnd   <= '0;
      endcase
    end
  end

  assign busy       = (r_fsm != IDLE);
  assign ciphertext = out_valid ? r_state : '0;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl: FIPS-197 / SP800-38A vectors on the 128-bit
// instance, plus AES-192 and AES-256 instances for the longer key schedules.
module tb_aes_iter_ctrl;

  localparam logic [127:0] PT_C     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] KEY_C2   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_C2    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KEY_NIST = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_N1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_N1    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CT_ZERO  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstN;
  logic         inValid, inReady, outValid, outReady, busy;
  logic [127:0] pt, key, ct;
  logic         inValidP, outReadyP;
  logic [127:0] ptP;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         inReady192, outValid192, busy192;
  logic         inReady256, outValid256, busy256;
  logic [127:0] ct192, ct256;

  int total = 0;
  int bad   = 0;

  aes_iter_ctrl #(.N(128), .Nr(10), .Nk(4)) d128 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .plaintext(pt), .key(key), .out_valid(outValid), .out_ready(outReady),
    .ciphertext(ct), .busy(busy));

  aes_iter_ctrl #(.N(192), .Nr(12), .Nk(6)) d192 (
    .clk(clk), .rst_n(rstN), .in_valid(inValidP), .in_ready(inReady192),
    .plaintext(ptP), .key(key192), .out_valid(outValid192), .out_ready(outReadyP),
    .ciphertext(ct192), .busy(busy192));

  aes_iter_ctrl #(.N(256), .Nr(14), .Nk(8)) d256 (
    .clk(clk), .rst_n(rstN), .in_valid(inValidP), .in_ready(inReady256),
    .plaintext(ptP), .key(key256), .out_valid(outValid256), .out_ready(outReadyP),
    .ciphertext(ct256), .busy(busy256));

  // Presents one block to the 128-bit instance; returns just after the accept edge.
  task automatic applyStimulus(input logic [127:0] p, input logic [127:0] k);
    @(negedge clk);
    pt      = p;
    key     = k;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Counts rising edges, the accept edge being edge 1, until out_valid is seen; -1 on timeout.
  task automatic waitOutput(output int edges);
    edges = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (outValid === 1'b1) return;
      edges++;
    end
    edges = -1;
  endtask

  task automatic test_reset();
    int e;
    rstN = 1'b0; inValid = 1'b1; pt = PT_C; key = KEY_C1; outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", outValid); end
    total++; if (ct !== 128'h0) begin bad++; $display("[TB] FAIL reset_ciphertext: got %h want 0", ct); end
    rstN = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0; pt = '1; key = '1;
    total++; if (busy !== 1'b1 || inReady !== 1'b0) begin bad++; $display("[TB] FAIL first_accept: busy=%b in_ready=%b want 1/0", busy, inReady); end
    waitOutput(e);
    total++; if (e !== 12) begin bad++; $display("[TB] FAIL c1_latency: got %0d want 12", e); end
    total++; if (ct !== CT_C1) begin bad++; $display("[TB] FAIL c1_value: got %h want %h", ct, CT_C1); end
    @(negedge clk);
    total++; if (outValid !== 1'b0 || ct !== 128'h0) begin bad++; $display("[TB] FAIL c1_handshake: out_valid=%b ct=%h want 0/0", outValid, ct); end
  endtask

  task automatic test_backpressure();
    int e;
    outReady = 1'b0;
    applyStimulus(PT_B, KEY_NIST);
    waitOutput(e);
    total++; if (e !== 12) begin bad++; $display("[TB] FAIL bp_latency: got %0d want 12", e); end
    total++; if (ct !== CT_B) begin bad++; $display("[TB] FAIL bp_value: got %h want %h", ct, CT_B); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (outValid !== 1'b1 || ct !== CT_B || inReady !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: out_valid=%b in_ready=%b ct=%h want 1/0/%h", i, outValid, inReady, ct, CT_B);
      end
    end
    outReady = 1'b1;
    @(negedge clk);
    total++; if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", outValid, inReady, busy); end
  endtask

  task automatic test_busy_input();
    int edges;
    int leak;
    outReady = 1'b0;
    applyStimulus(PT_N1, KEY_NIST);
    inValid = 1'b1;
    edges = 1;
    leak  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (outValid === 1'b1) break;
      if (inReady !== 1'b0) leak++;
      edges++;
      pt       = {$urandom(), $urandom(), $urandom(), $urandom()};
      key      = {$urandom(), $urandom(), $urandom(), $urandom()};
      outReady = ~outReady;
    end
    outReady = 1'b0;
    inValid  = 1'b0;
    total++; if (edges !== 12) begin bad++; $display("[TB] FAIL busy_latency: got %0d want 12", edges); end
    total++; if (leak !== 0) begin bad++; $display("[TB] FAIL busy_in_ready: %0d cycles with in_ready high, want 0", leak); end
    total++; if (ct !== CT_N1) begin bad++; $display("[TB] FAIL busy_value: got %h want %h", ct, CT_N1); end
    outReady = 1'b1;
    @(negedge clk);
    total++; if (outValid !== 1'b0 || inReady !== 1'b1) begin bad++; $display("[TB] FAIL busy_release: out_valid=%b in_ready=%b want 0/1", outValid, inReady); end
  endtask

  task automatic test_reset_mid();
    int e;
    outReady = 1'b1;
    applyStimulus(128'h0, 128'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (d128.r_rnd !== 4'd5 || busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_round: rnd=%0d busy=%b want 5/1", d128.r_rnd, busy); end
    rstN = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || outValid !== 1'b0 || ct !== 128'h0 || inReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset: busy=%b out_valid=%b in_ready=%b ct=%h want 0/0/1/0", busy, outValid, inReady, ct);
    end
    rstN = 1'b1;
    applyStimulus(128'h0, 128'h0);
    waitOutput(e);
    total++; if (e !== 12) begin bad++; $display("[TB] FAIL mid_latency: got %0d want 12", e); end
    total++; if (ct !== CT_ZERO) begin bad++; $display("[TB] FAIL mid_value: got %h want %h", ct, CT_ZERO); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vPt [7];
    logic [127:0] vKey [7];
    logic [127:0] vCt [7];
    int sent, recv, cyc, lastCyc;
    vPt  = '{PT_C, PT_B, PT_N1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h0,
             128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    vKey = '{KEY_C1, KEY_NIST, KEY_NIST, KEY_NIST, 128'h0, KEY_NIST, KEY_NIST};
    vCt  = '{CT_C1, CT_B, CT_N1, 128'hf5d3d58503b9699de785895a96fdbaaf, CT_ZERO,
             128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};
    outReady = 1'b1;
    inValid  = 1'b0;
    sent = 0; recv = 0; cyc = 0; lastCyc = 0;
    while (recv < 7 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (outValid === 1'b1) begin
        total++; if (ct !== vCt[recv]) begin bad++; $display("[TB] FAIL b2b_value[%0d]: got %h want %h", recv, ct, vCt[recv]); end
        if (recv > 0) begin
          total++; if (cyc - lastCyc !== 13) begin bad++; $display("[TB] FAIL b2b_period[%0d]: got %0d want 13", recv, cyc - lastCyc); end
        end
        lastCyc = cyc;
        recv++;
      end
      if (inReady === 1'b1 && sent < 7) begin
        pt = vPt[sent]; key = vKey[sent]; inValid = 1'b1;
        sent++;
      end
    end
    inValid = 1'b0;
    total++; if (recv !== 7) begin bad++; $display("[TB] FAIL b2b_count: got %0d results want 7", recv); end
  endtask

  task automatic test_params();
    int e192, e256;
    ptP = PT_C; key192 = KEY_C2; key256 = KEY_C3; outReadyP = 1'b0;
    @(negedge clk);
    inValidP = 1'b1;
    @(posedge clk);
    #1;
    inValidP = 1'b0; ptP = '1; key192 = '1; key256 = '1;
    e192 = -1;
    e256 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (outValid192 === 1'b1 && e192 < 0) e192 = i;
      if (outValid256 === 1'b1 && e256 < 0) e256 = i;
      if (e192 > 0 && e256 > 0) break;
    end
    total++; if (e192 !== 14) begin bad++; $display("[TB] FAIL aes192_latency: got %0d want 14", e192); end
    total++; if (ct192 !== CT_C2) begin bad++; $display("[TB] FAIL aes192_value: got %h want %h", ct192, CT_C2); end
    total++; if (e256 !== 16) begin bad++; $display("[TB] FAIL aes256_latency: got %0d want 16", e256); end
    total++; if (ct256 !== CT_C3) begin bad++; $display("[TB] FAIL aes256_value: got %h want %h", ct256, CT_C3); end
    outReadyP = 1'b1;
    @(negedge clk);
    total++; if (outValid192 !== 1'b0 || outValid256 !== 1'b0) begin bad++; $display("[TB] FAIL params_release: out_valid192=%b out_valid256=%b want 0/0", outValid192, outValid256); end
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b0; pt = '0; key = '0;
    inValidP = 1'b0; outReadyP = 1'b0; ptP = '0; key192 = '0; key256 = '0;
    $display("[TB] starting aes_iter_ctrl bench");
    test_reset();
    test_backpressure();
    test_busy_input();
    test_reset_mid();
    test_back_to_back();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
